if_unit: RTL and testbench

Instruction-fetch stage of the five-stage LoongArch pipeline, sitting directly upstream of the decode stage. It owns the architectural fetch PC and issues one read per cycle to the synchronous instruction SRAM. It delivers `{pc, inst}` to decode under a valid/ready handshake and redirects on the branch bus that decode drives back. An optional holding buffer keeps the fetched word stable while decode stalls.

---
 rtl/if_unit_if.sv | 25 ++
 rtl/if_unit.sv | 95 +++++++++
 tb/tb_if_unit.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/if_unit_if.sv
// Fetch-stage signal bundle: decode handshake, branch bus and instruction SRAM port.
// The master modport is the fetch unit; the slave modport is its environment.
interface if_unit_if;
  logic [32:0] br_bus;
  logic        ID_Unit_Ready;
  logic        IF_Valid;
  logic [63:0] IF_to_ID_Bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  modport master (
    input  br_bus, ID_Unit_Ready, inst_sram_rdata,
    output IF_Valid, IF_to_ID_Bus, inst_sram_en, inst_sram_we,
           inst_sram_addr, inst_sram_wdata
  );

  modport slave (
    output br_bus, ID_Unit_Ready, inst_sram_rdata,
    input  IF_Valid, IF_to_ID_Bus, inst_sram_en, inst_sram_we,
           inst_sram_addr, inst_sram_wdata
  );
endinterface

// File: rtl/if_unit.sv
// LoongArch instruction-fetch stage: owns the fetch PC, reads the sync SRAM, offers {pc, inst} to decode.
// Optional holding buffer for the stalled word is enabled by defining IF_INST_BUF_EN.
module if_unit #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic      clk,
  input  logic      resetn,
  if_unit_if.master bus
);

  logic        to_fs_valid_q, to_fs_valid_d;
  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q, fs_pc_d;

  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] nextpc;
  logic        fs_allowin;
  logic        sram_en;
  logic        if_valid;
  logic        transfer;
  logic [31:0] inst;

  // A taken branch cancels the word in IF and forces the target request out this cycle.
  assign br_taken   = bus.br_bus[32] & to_fs_valid_q;
  assign br_target  = bus.br_bus[31:0];
  assign nextpc     = br_taken ? br_target : fs_pc_q + 32'd4;
  assign fs_allowin = !fs_valid_q | bus.ID_Unit_Ready | br_taken;
  assign sram_en    = to_fs_valid_q & fs_allowin;
  assign if_valid   = fs_valid_q & !br_taken;
  assign transfer   = if_valid & bus.ID_Unit_Ready;

  always_comb begin
    to_fs_valid_d = 1'b1;
    fs_valid_d    = fs_valid_q;
    fs_pc_d       = fs_pc_q;
    if (sram_en) begin
      fs_valid_d = 1'b1;
      fs_pc_d    = nextpc;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_fs_valid_q <= 1'b0;
      fs_valid_q    <= 1'b0;
      fs_pc_q       <= RESET_PC - 32'd4;
    end else begin
      to_fs_valid_q <= to_fs_valid_d;
      fs_valid_q    <= fs_valid_d;
      fs_pc_q       <= fs_pc_d;
    end
  end

`ifdef IF_INST_BUF_EN
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_inst_q, buf_inst_d;

  // Capture the word on the first stalled edge; the SRAM output is untrusted afterwards.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_inst_d  = buf_inst_q;
    if (transfer || br_taken) begin
      buf_valid_d = 1'b0;
    end else if (fs_valid_q && !bus.ID_Unit_Ready && !buf_valid_q) begin
      buf_valid_d = 1'b1;
      buf_inst_d  = bus.inst_sram_rdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_valid_q <= 1'b0;
      buf_inst_q  <= 32'd0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_inst_q  <= buf_inst_d;
    end
  end

  assign inst = buf_valid_q ? buf_inst_q : bus.inst_sram_rdata;
`else
  logic unused_transfer;
  assign unused_transfer = transfer;
  assign inst = bus.inst_sram_rdata;
`endif

  assign bus.IF_Valid        = if_valid;
  assign bus.IF_to_ID_Bus    = {fs_pc_q, inst};
  assign bus.inst_sram_en    = sram_en;
  assign bus.inst_sram_we    = 4'b0;
  assign bus.inst_sram_addr  = nextpc;
  assign bus.inst_sram_wdata = 32'b0;

endmodule

// File: tb/tb_if_unit.sv
// Directed bench for if_unit: scoreboard of expected {pc, inst} transfers plus inline timing checks.
module tb_if_unit;

  localparam logic [31:0] RESET_PC = 32'h1c000000;

  logic clk;
  logic resetn;
  if_unit_if bus ();

  if_unit #(.RESET_PC(RESET_PC)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.master)
  );

  int checks   = 0;
  int failures = 0;
  logic [63:0] expQ[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'hdead_beef;
  endfunction

  // Sync-read SRAM model; with the buffer enabled it scribbles garbage while idle.
  always @(posedge clk) begin
    if (bus.inst_sram_en)
      bus.inst_sram_rdata <= memWord(bus.inst_sram_addr);
`ifdef IF_INST_BUF_EN
    else
      bus.inst_sram_rdata <= $urandom;
`endif
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic taken, input logic [31:0] target);
    bus.ID_Unit_Ready = rdy;
    bus.br_bus        = {taken, target};
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic expectPc(input logic [31:0] pc);
    expQ.push_back({pc, memWord(pc)});
  endtask

  // Monitor: every accepted transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (resetn && bus.IF_Valid && bus.ID_Unit_Ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_transfer", bus.IF_to_ID_Bus, 64'hx);
      end else begin
        checkOutput("transfer", bus.IF_to_ID_Bus, expQ.pop_front());
      end
    end
  end

  logic [63:0] held;

  initial begin
    bus.inst_sram_rdata = 32'h0;
    resetn = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0);

    @(negedge clk);
    checkOutput("rst_valid", 64'(bus.IF_Valid), 64'd0);
    checkOutput("rst_en", 64'(bus.inst_sram_en), 64'd0);
    checkOutput("rst_addr", 64'(bus.inst_sram_addr), 64'(RESET_PC));
    checkOutput("rst_pc", 64'(bus.IF_to_ID_Bus[63:32]), 64'(RESET_PC - 32'd4));
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    @(negedge clk);
    checkOutput("release_en", 64'(bus.inst_sram_en), 64'd0);

    expectPc(32'h1c000000);
    expectPc(32'h1c000004);
    nextEdge();
    applyStimulus(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("first_en", 64'(bus.inst_sram_en), 64'd1);
    checkOutput("first_addr", 64'(bus.inst_sram_addr), 64'h1c000000);

    nextEdge();
    nextEdge();
    nextEdge();
    applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    held = bus.IF_to_ID_Bus;
    checkOutput("stall_bus", held, {32'h1c000008, memWord(32'h1c000008)});
    checkOutput("stall_valid", 64'(bus.IF_Valid), 64'd1);
    checkOutput("stall_en", 64'(bus.inst_sram_en), 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("stall_stable", bus.IF_to_ID_Bus, held);
      checkOutput("stall_en_hold", 64'(bus.inst_sram_en), 64'd0);
    end

    expectPc(32'h1c000008);
    expectPc(32'h1c000100);
    nextEdge();
    applyStimulus(1'b1, 1'b0, 32'h0);
    nextEdge();
    applyStimulus(1'b1, 1'b1, 32'h1c000100);
    @(negedge clk);
    checkOutput("redir_valid", 64'(bus.IF_Valid), 64'd0);
    checkOutput("redir_en", 64'(bus.inst_sram_en), 64'd1);
    checkOutput("redir_addr", 64'(bus.inst_sram_addr), 64'h1c000100);

    nextEdge();
    applyStimulus(1'b1, 1'b0, 32'h0);
    nextEdge();
    applyStimulus(1'b0, 1'b0, 32'h0);
    nextEdge();
    expectPc(32'h1c000200);
    expectPc(32'h1c000204);
    applyStimulus(1'b0, 1'b1, 32'h1c000200);
    @(negedge clk);
    checkOutput("bstall_valid", 64'(bus.IF_Valid), 64'd0);
    checkOutput("bstall_en", 64'(bus.inst_sram_en), 64'd1);
    checkOutput("bstall_addr", 64'(bus.inst_sram_addr), 64'h1c000200);

    nextEdge();
    applyStimulus(1'b1, 1'b0, 32'h0);
    nextEdge();
    nextEdge();
    #2 resetn = 1'b0;
    #1;
    checkOutput("arst_valid", 64'(bus.IF_Valid), 64'd0);
    checkOutput("arst_en", 64'(bus.inst_sram_en), 64'd0);
    checkOutput("arst_addr", 64'(bus.inst_sram_addr), 64'(RESET_PC));

    repeat (2) @(posedge clk);
    expectPc(32'h1c000000);
    expectPc(32'h1c000004);
    expectPc(32'h1c000008);
    #1 resetn = 1'b1;

    begin : drain
      int budget;
      budget = 20;
      while (expQ.size() != 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      bus.ID_Unit_Ready = 1'b0;
    end
    checkOutput("drain_empty", 64'(expQ.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
